// File: rtl/fibo_check.sv
// Purpose : receive-side checker for the 8-bit Fibonacci LED stream (lock, per-term error, stats).
// Latency : 1 clk; the response to a strobe at cycle N is visible at cycle N+1.
// Backpr. : none; every in_valid strobe is consumed, idle cycles change nothing.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   in         - observed Fibonacci term, sampled when in_valid=1
//   in_valid   - one-cycle strobe (generator clock-enable)
//   locked     - high while the stream verifies in sequence
//   err        - one-cycle pulse on a mismatched term
//   err_count  - mismatches seen, saturating at 255
//   term_count - terms matched while locked, saturating at 65535
//   period_err - one-cycle pulse on strobe-spacing violation
//
// Optional feature macro: FIBO_CHECK_PERIOD_EN (strobe spacing check against DECIMATION).
// When undefined, period_err is tied low and no spacing counter exists.

module fibo_check #(
  parameter logic [19:0] DECIMATION   = 20'd16,
  parameter int unsigned LOCK_CONFIRM = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in,
  input  logic        in_valid,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] term_count,
  output logic        period_err
);

  localparam logic [1:0] ST_ACQ0    = 2'd0;
  localparam logic [1:0] ST_ACQ1    = 2'd1;
  localparam logic [1:0] ST_CONFIRM = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam logic [3:0] CONFIRM_TGT = 4'(LOCK_CONFIRM);

  logic [1:0] state;
  logic [7:0] p1;
  logic [7:0] p2;
  logic [3:0] confirm;

  // 8-bit add wraps naturally, giving the mod-256 expected term.
  logic [7:0] exp_term;
  logic       match;
  assign exp_term = p1 + p2;
  assign match    = (in == exp_term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_ACQ0;
      p1         <= 8'd0;
      p2         <= 8'd0;
      confirm    <= 4'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= 8'd0;
      term_count <= 16'd0;
    end else begin
      err <= 1'b0;
      if (in_valid) begin
        // History always shifts, so a bad sample becomes part of the
        // reference for the next terms and re-lock is measured against it.
        p1 <= in;
        if (state != ST_ACQ0) p2 <= p1;
        case (state)
          ST_ACQ0: state <= ST_ACQ1;
          ST_ACQ1: begin
            confirm <= 4'd0;
            state   <= ST_CONFIRM;
          end
          ST_CONFIRM: begin
            if (match) begin
              confirm <= confirm + 4'd1;
              if (confirm + 4'd1 == CONFIRM_TGT) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              err     <= 1'b1;
              confirm <= 4'd0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
          ST_LOCKED: begin
            if (match) begin
              if (term_count != 16'hFFFF) term_count <= term_count + 16'd1;
            end else begin
              err     <= 1'b1;
              locked  <= 1'b0;
              confirm <= 4'd0;
              state   <= ST_CONFIRM;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        endcase
      end
    end
  end

`ifdef FIBO_CHECK_PERIOD_EN
  // gap_cnt holds (cycles since last strobe - 1) at the next strobe edge,
  // so nominal spacing shows up as DECIMATION-1.
  logic [19:0] gap_cnt;
  logic        per_armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt    <= 20'd0;
      per_armed  <= 1'b0;
      period_err <= 1'b0;
    end else begin
      period_err <= 1'b0;
      if (in_valid) begin
        gap_cnt <= 20'd0;
        // Only checking states count; the first checked strobe just arms.
        if (state[1]) begin
          per_armed <= 1'b1;
          if (per_armed && (gap_cnt != DECIMATION - 20'd1)) period_err <= 1'b1;
        end
      end else if (gap_cnt != 20'hFFFFF) begin
        gap_cnt <= gap_cnt + 20'd1;
      end
    end
  end
`else
  logic unused_decimation;
  assign unused_decimation = ^DECIMATION;
  assign period_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fibo_check.sv
module tb_fibo_check;

  logic        clk;
  logic        reset;
  logic [7:0]  in;
  logic        in_valid;
  logic        locked;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] term_count;
  logic        period_err;

  fibo_check dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .term_count (term_count),
    .period_err (period_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [7:0]  errc;
    logic [15:0] termc;
    logic        per;
  } obs_t;

  obs_t sb_q[$];
  int   checks;
  int   failures;
  int   cyc;
  int   last_cyc;
  int   per_pulses;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (period_err === 1'b1) per_pulses <= per_pulses + 1;

  // Reference model state
  int         m_state;
  logic [7:0] m_p1, m_p2;
  int         m_conf;
  logic       m_locked;
  int         m_errc;
  int         m_termc;
  logic       m_armed;

  // Generator state
  logic [7:0] g_a, g_b;

  task automatic model_reset();
    m_state = 0; m_p1 = 0; m_p2 = 0; m_conf = 0;
    m_locked = 0; m_errc = 0; m_termc = 0; m_armed = 0;
  endtask

  task automatic model_step(input logic [7:0] v, input int sp, output obs_t e);
    logic [7:0] expv;
    logic       e_err, e_per;
    expv  = m_p1 + m_p2;
    e_err = 0;
    e_per = 0;
    if (m_state >= 2) begin
`ifdef FIBO_CHECK_PERIOD_EN
      if (m_armed && sp != 16) e_per = 1;
`endif
      m_armed = 1;
      if (v == expv) begin
        if (m_state == 2) begin
          m_conf++;
          if (m_conf == 2) begin m_state = 3; m_locked = 1; end
        end else if (m_termc < 65535) m_termc++;
      end else begin
        e_err = 1;
        if (m_errc < 255) m_errc++;
        m_conf = 0;
        m_locked = 0;
        m_state = 2;
      end
    end else if (m_state == 1) begin
      m_conf = 0;
      m_state = 2;
    end else begin
      m_state = 1;
    end
    if (m_state != 1 || sp >= 0) m_p2 = (m_state == 1) ? m_p2 : m_p1;
    m_p1 = v;
    e = {m_locked, e_err, 8'(m_errc), 16'(m_termc), e_per};
  endtask

  // One strobe; gap = cycles from this strobe to the next one.
  task automatic send(input logic [7:0] v, input int gap, input bit chk);
    obs_t e, got;
    int   sp;
    @(negedge clk);
    in = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sp = cyc - last_cyc;
    last_cyc = cyc;
    model_step(v, sp, e);
    sb_q.push_back(e);
    got = {locked, err, err_count, term_count, period_err};
    e = sb_q.pop_front();
    if (chk) begin
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL sb in=%0d got l=%b e=%b ec=%0d tc=%0d pe=%b exp l=%b e=%b ec=%0d tc=%0d pe=%b",
                 v, got.locked, got.err, got.errc, got.termc, got.per,
                 e.locked, e.err, e.errc, e.termc, e.per);
      end
    end
    if (gap > 1) begin
      @(posedge clk);
      #1;
      if (chk) begin
        checks++;
        if (err !== 1'b0 || period_err !== 1'b0) begin
          failures++;
          $display("FAIL idle_pulse err=%b period_err=%b exp 0/0", err, period_err);
        end
      end
      repeat (gap - 2) @(posedge clk);
    end
  endtask

  task automatic gen_reset();
    g_a = 8'd1;
    g_b = 8'd1;
  endtask

  task automatic send_gen(input int n, input int gap, input bit chk);
    logic [7:0] v, t;
    for (int i = 0; i < n; i++) begin
      v = g_a;
      t = g_a + g_b;
      g_a = g_b;
      g_b = t;
      send(v, gap, chk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    sb_q.delete();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({locked, err, err_count, term_count, period_err} !== 26'd0) begin
      failures++;
      $display("FAIL reset_state l=%b e=%b ec=%0d tc=%0d pe=%b exp all 0",
               locked, err, err_count, term_count, period_err);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_clean();
    gen_reset();
    send_gen(3, 16, 1);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL clean_prelock locked=%b exp 0", locked); end
    send_gen(1, 16, 1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL clean_lock locked=%b exp 1", locked); end
    send_gen(16, 16, 1);
    checks++;
    if (term_count !== 16'd16 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL clean_counts tc=%0d ec=%0d exp 16/0", term_count, err_count);
    end
  endtask

  task automatic test_wrap();
    send_gen(5, 16, 1);
    checks++;
    if (term_count !== 16'd21 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_cont tc=%0d ec=%0d exp 21/0", term_count, err_count);
    end
    do_reset();
    send(8'd89, 4, 1);
    send(8'd144, 4, 1);
    send(8'd233, 4, 1);
    send(8'd121, 4, 1);
    send(8'd98, 4, 1);
    checks++;
    if (locked !== 1'b1 || term_count !== 16'd1 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_mod256 l=%b tc=%0d ec=%0d exp 1/1/0", locked, term_count, err_count);
    end
  endtask

  task automatic test_corrupt(input bit alt);
    do_reset();
    gen_reset();
    send_gen(7, 16, 1);
    send(8'd22, 1, 1);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL corrupt_22 e=%b l=%b ec=%0d exp 1/0/1", err, locked, err_count);
    end
    repeat (15) @(posedge clk);
    send(8'd34, 1, 1);
    checks++;
    if (err !== 1'b1 || err_count !== 8'd2) begin
      failures++;
      $display("FAIL corrupt_34 e=%b ec=%0d exp 1/2", err, err_count);
    end
    repeat (15) @(posedge clk);
    send(alt ? 8'd55 : 8'd56, 1, 1);
    checks++;
    if (err !== alt || err_count !== (alt ? 8'd3 : 8'd2)) begin
      failures++;
      $display("FAIL corrupt_next alt=%0d e=%b ec=%0d exp %b/%0d", alt, err, err_count, alt, alt ? 3 : 2);
    end
    repeat (15) @(posedge clk);
  endtask

  task automatic test_restart();
    do_reset();
    gen_reset();
    send_gen(10, 16, 1);
    gen_reset();
    send_gen(4, 16, 1);
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd2) begin
      failures++;
      $display("FAIL restart l=%b ec=%0d exp 1/2", locked, err_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    gen_reset();
    send_gen(6, 16, 1);
    checks++;
    if (locked !== 1'b1 || term_count !== 16'd2) begin
      failures++;
      $display("FAIL async_pre l=%b tc=%0d exp 1/2", locked, term_count);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({locked, err, err_count, term_count, period_err} !== 26'd0) begin
      failures++;
      $display("FAIL async_clear l=%b e=%b ec=%0d tc=%0d pe=%b exp all 0",
               locked, err, err_count, term_count, period_err);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    sb_q.delete();
    gen_reset();
    send_gen(4, 16, 1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL async_relock locked=%b exp 1", locked); end
  endtask

  task automatic test_period();
`ifdef FIBO_CHECK_PERIOD_EN
    int base;
    do_reset();
    gen_reset();
    send_gen(6, 16, 1);
    base = per_pulses;
    send_gen(3, 16, 1);
    send_gen(1, 17, 1);
    send_gen(4, 16, 1);
    checks++;
    if (per_pulses - base !== 1 || err_count !== 8'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL period_gap pulses=%0d ec=%0d l=%b exp 1/0/1", per_pulses - base, err_count, locked);
    end
`else
    checks++;
    if (per_pulses !== 0) begin
      failures++;
      $display("FAIL period_tied pulses=%0d exp 0", per_pulses);
    end
`endif
  endtask

  task automatic test_sat_err();
    logic [7:0] v;
    do_reset();
    gen_reset();
    send_gen(4, 2, 1);
    for (int i = 0; i < 300; i++) begin
      v = m_p1 + m_p2 + 8'd1;
      send(v, 1, 1);
    end
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_err ec=%0d exp 255", err_count);
    end
  endtask

  task automatic test_sat_term();
    do_reset();
    gen_reset();
    send_gen(65545, 1, 0);
    send_gen(3, 1, 1);
    checks++;
    if (term_count !== 16'hFFFF || locked !== 1'b1) begin
      failures++;
      $display("FAIL sat_term tc=%0d l=%b exp 65535/1", term_count, locked);
    end
  endtask

  initial begin
    reset      = 1'b0;
    in         = 8'd0;
    in_valid   = 1'b0;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    last_cyc   = 0;
    per_pulses = 0;
    gen_reset();
    model_reset();
    test_reset();
    test_clean();
    test_wrap();
    test_corrupt(1'b0);
    test_corrupt(1'b1);
    test_restart();
    test_async_reset();
    test_period();
    test_sat_err();
    test_sat_term();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
